// File: rtl/aes_inv_round_if.sv
// Handshake and data bundle for the iterative AES inverse-round engine.
// The round controller drives the master side and the engine is the slave.
interface aes_inv_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid, in_state, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_key, in_last, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/aes_inv_round.sv
// Iterative single-round AES decryption engine.
// One column per cycle: InvShiftRows gather, four arithmetic inverse S-boxes,
// AddRoundKey, then InvMixColumns unless the captured round is the last one.
module aes_inv_round (
    input  logic           clk,
    input  logic           rst_n,
    aes_inv_round_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic         accept_s;
    logic [127:0] st_cap_r;
    logic [127:0] key_cap_r;
    logic         last_cap_r;
    logic [1:0]   cnt_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [127:0] out_state_r;
    logic [31:0]  sub_s;
    logic [31:0]  key_col_s;
    logic [31:0]  ark_s;
    logic [31:0]  col_s;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product, shift-and-add over xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            else      acc = acc;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box: inverse affine map followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Constant multiply by a 4-bit coefficient built from xtime chains.
    function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2;
        logic [7:0] a4;
        logic [7:0] a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^
               (k[1] ? a2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    // InvMixColumns on one column, row 0 in the most significant byte.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mul_k(a0, 4'he) ^ mul_k(a1, 4'hb) ^ mul_k(a2, 4'hd) ^ mul_k(a3, 4'h9),
                mul_k(a0, 4'h9) ^ mul_k(a1, 4'he) ^ mul_k(a2, 4'hb) ^ mul_k(a3, 4'hd),
                mul_k(a0, 4'hd) ^ mul_k(a1, 4'h9) ^ mul_k(a2, 4'he) ^ mul_k(a3, 4'hb),
                mul_k(a0, 4'hb) ^ mul_k(a1, 4'hd) ^ mul_k(a2, 4'h9) ^ mul_k(a3, 4'he)};
    endfunction

    // Gather column cnt_r through InvShiftRows and pass each byte through an inverse S-box.
    always_comb begin
        sub_s = 32'h0000_0000;
        for (int r = 0; r < 4; r++) begin
            sub_s[31 - 8*r -: 8] =
                inv_sbox(st_cap_r[127 - 8*(4*((int'(cnt_r) + 4 - r) % 4) + r) -: 8]);
        end
    end

    // Add the round key column and optionally mix.
    always_comb begin
        key_col_s = key_cap_r[127 - 32*int'(cnt_r) -: 32];
        ark_s     = sub_s ^ key_col_s;
        if (last_cap_r) col_s = ark_s;
        else            col_s = inv_mix(ark_s);
    end

    // Next-state logic of the IDLE/RUN/DONE controller.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 2'd3) state_s = DONE;
                else               state_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Capture the round inputs on acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cap_r   <= 128'h0;
            key_cap_r  <= 128'h0;
            last_cap_r <= 1'b0;
        end else if (accept_s) begin
            st_cap_r   <= bus.in_state;
            key_cap_r  <= bus.in_key;
            last_cap_r <= bus.in_last;
        end
    end

    // Column counter and column-wise result write-back during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 2'd0;
            out_state_r <= 128'h0;
        end else if (accept_s) begin
            cnt_r <= 2'd0;
        end else if (state_r == RUN) begin
            out_state_r[127 - 32*int'(cnt_r) -: 32] <= col_s;
            cnt_r <= cnt_r + 2'd1;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_state = out_state_r;
endmodule

// File: tb/tb_aes_inv_round.sv
// Self-checking bench for aes_inv_round: a table-driven reference round
// (S-box table built by brute-force field inversion) plus directed and
// randomized rounds, checked every cycle by a single monitor.
module tb_aes_inv_round;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_inv_round_if ifc ();
    aes_inv_round dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    localparam logic [127:0] R1_S  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] R1_K  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] R1_O  = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] FN_S  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] FN_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FN_O  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R2_K  = 128'h47438735a41c65b9e016baf4aebf7ad2;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] isb [256];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        d = d << n;
        return d[15:8];
    endfunction

    // Forward S-box by search for the inverse, then invert the table.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k,
                                                 input logic l);
        logic [7:0] a [4][4];
        logic [7:0] t [4][4];
        logic [7:0] base [4];
        logic [7:0] acc;
        logic [127:0] res;
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) a[r][c] = s[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][(c + r) % 4] = isb[a[r][c]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][c] = t[r][c] ^ k[127 - 8*(4*c + r) -: 8];
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (l) acc = t[r][c];
                else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - r + 4) % 4], t[j][c]);
                end
                res[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    // Monitor state: pending results, busy flag and acceptance time.
    logic [127:0] exp_q [$];
    logic [127:0] last_out = 128'h0;
    bit busy = 1'b0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy = 1'b0;
            exp_q.delete();
            chk1("rst_in_ready", ifc.in_ready, 1'b1);
            chk1("rst_out_valid", ifc.out_valid, 1'b0);
            chk("rst_out_state", ifc.out_state, 128'h0);
        end else begin
            chk1("in_ready", ifc.in_ready, !busy);
            chk1("out_valid", ifc.out_valid, busy && (cyc >= acc_cyc + 5));
            if (ifc.out_valid && exp_q.size() > 0) chk("out_state", ifc.out_state, exp_q[0]);
            if (ifc.in_valid && ifc.in_ready) begin
                exp_q.push_back(model_round(ifc.in_state, ifc.in_key, ifc.in_last));
                busy = 1'b1;
                acc_cyc = cyc;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                last_out = ifc.out_state;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                busy = 1'b0;
            end
        end
    end

    bit rand_ready = 1'b0;

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l);
        bit was;
        bit ok;
        ok = 1'b0;
        ifc.in_valid = 1'b1; ifc.in_state = s; ifc.in_key = k; ifc.in_last = l;
        for (int i = 0; i < 200; i++) begin
            was = ifc.in_ready;
            cycle();
            if (was) begin ok = 1'b1; break; end
        end
        ifc.in_valid = 1'b0;
        ifc.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        ifc.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        ifc.in_last  = 1'($urandom_range(0, 1));
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: got no in_ready, expected acceptance");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            cycle();
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: got busy, expected round completion");
        end
    endtask

    initial begin
        logic [127:0] hold;
        logic [127:0] r2_in;
        bit seen;
        rst_n = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_state = 128'h0; ifc.in_key = 128'h0;
        ifc.in_last = 1'b0; ifc.out_ready = 1'b0;
        build_tables();

        chk("model_isb_63", {120'h0, isb[8'h63]}, 128'h00);
        chk("model_isb_00", {120'h0, isb[8'h00]}, 128'h52);
        chk("model_isb_7c", {120'h0, isb[8'h7c]}, 128'h01);
        chk("model_round1", model_round(R1_S, R1_K, 1'b0), R1_O);
        chk("model_final", model_round(FN_S, FN_K, 1'b1), FN_O);

        repeat (3) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("idle_out_state", ifc.out_state, 128'h0);
        end

        ifc.out_ready = 1'b1;
        send(R1_S, R1_K, 1'b0);
        drain();
        chk("c1_round1", last_out, R1_O);

        send(FN_S, FN_K, 1'b1);
        drain();
        chk("c1_final", last_out, FN_O);

        // Backpressure: hold DONE with out_ready low while upstream keeps toggling.
        ifc.out_ready = 1'b0;
        send(R1_S, R1_K, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ifc.out_valid) begin seen = 1'b1; break; end
            cycle();
        end
        chk1("bp_reached_done", seen, 1'b1);
        hold = ifc.out_state;
        chk("bp_result", hold, R1_O);
        for (int i = 0; i < 10; i++) begin
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
            chk1("bp_out_valid", ifc.out_valid, 1'b1);
            chk("bp_stable", ifc.out_state, hold);
            chk1("bp_in_ready", ifc.in_ready, 1'b0);
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        cycle();
        chk1("bp_release_valid", ifc.out_valid, 1'b0);
        chk1("bp_release_ready", ifc.in_ready, 1'b1);

        // Back-to-back: feed a finished round straight into the next one.
        send(R1_S, R1_K, 1'b0);
        drain();
        r2_in = last_out;
        send(r2_in, R2_K, 1'b0);
        drain();
        chk("b2b_round2", last_out, model_round(R1_O, R2_K, 1'b0));

        // Abort mid-RUN with an asynchronous reset.
        send(R1_S, R1_K, 1'b0);
        cycle();
        rst_n = 1'b0;
        #1;
        chk1("abort_out_valid", ifc.out_valid, 1'b0);
        chk("abort_out_state", ifc.out_state, 128'h0);
        chk1("abort_in_ready", ifc.in_ready, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        send(R1_S, R1_K, 1'b0);
        drain();
        chk("after_abort", last_out, R1_O);

        // Randomized rounds with random backpressure and idle gaps.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send({$urandom(), $urandom(), $urandom(), $urandom()},
                 {$urandom(), $urandom(), $urandom(), $urandom()},
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) cycle();
        end
        drain();
        rand_ready = 1'b0;
        ifc.out_ready = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
